// File: rtl/calc_axil_sequencer_pkg.sv
// Shared types and constants for the my_calc AXI4-Lite sequencer.
// Holds the FSM state encoding, the calculator register map and the AXI response codes.
package calc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_CTL,
    ST_RD_RES,
    ST_RSP
  } seq_state_e;

  localparam logic [7:0] CALC_REG_A   = 8'h0;
  localparam logic [7:0] CALC_REG_B   = 8'h4;
  localparam logic [7:0] CALC_REG_CTL = 8'h8;
  localparam logic [7:0] CALC_REG_RES = 8'hC;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/calc_axil_sequencer_if.sv
// AXI4-Lite bus bundle between the sequencer (master) and a my_calc slave.
interface calc_axil_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/calc_axil_xfer.sv
// Single AXI4-Lite write or read engine; a start pulse loads a request, done_o flags the B/R beat.
// A new start is accepted in the same cycle as done_o so back-to-back accesses take two cycles.
module calc_axil_xfer
  import calc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        resp_o,
  calc_axil_sequencer_if.master m_axi
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic wr_act_q, wr_act_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;
  assign b_hs  = bready_q & m_axi.bvalid;
  assign ar_hs = arvalid_q & m_axi.arready;
  assign r_hs  = rready_q & m_axi.rvalid;

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wr_act_d  = wr_act_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs)  wvalid_d  = 1'b0;
    // bready only after both AW and W are done, whichever order they finish in
    if (wr_act_q && (!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
      bready_d = 1'b1;
      wr_act_d = 1'b0;
    end
    if (b_hs) bready_d = 1'b0;
    if (ar_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (r_hs) rready_d = 1'b0;
    if (start_i) begin
      awvalid_d = write_i;
      wvalid_d  = write_i;
      wr_act_d  = write_i;
      bready_d  = 1'b0;
      arvalid_d = ~write_i;
      rready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      if (start_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_act_q  <= wr_act_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign done_o  = b_hs | r_hs;
  assign resp_o  = bready_q ? m_axi.bresp : m_axi.rresp;
  assign rdata_o = m_axi.rdata;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: rtl/calc_axil_sequencer.sv
// Drives one my_calc slave through write A, write B, write control, read result for each command.
//   state     | meaning
//   IDLE      | cmd_ready high, waiting for a command
//   WR_A      | writing operand A
//   WR_B      | writing operand B
//   WR_CTL    | writing the opcode to the control register
//   RD_RES    | reading the result register
//   RSP       | presenting result/error until rsp_ready
module calc_axil_sequencer
  import calc_seq_pkg::*;
#(
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] C_CALC_BASE = '0
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] cmd_a,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] cmd_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_result,
  output logic                            rsp_err,
  output logic                            busy,
  output logic [15:0]                     done_count,
  calc_axil_sequencer_if.master           m00_axi
);

  localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;

  seq_state_e state_q, state_d;
  logic [1:0]    op_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   done_count_q, done_count_d;
  logic          cmd_ready_q, busy_q, rsp_valid_q;

  logic          xfer_start, xfer_write, xfer_done;
  logic [AW-1:0] xfer_addr;
  logic [DW-1:0] xfer_wdata, xfer_rdata;
  logic [1:0]    xfer_resp;
  logic          cmd_hs, rsp_hs;

  assign cmd_hs = cmd_valid & cmd_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  always_comb begin
    state_d      = state_q;
    xfer_start   = 1'b0;
    xfer_write   = 1'b1;
    xfer_addr    = C_CALC_BASE + AW'(CALC_REG_A);
    xfer_wdata   = cmd_a;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    done_count_d = done_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          xfer_start   = 1'b1;
          rsp_result_d = '0;
          rsp_err_d    = 1'b0;
          state_d      = ST_WR_A;
        end
      end
      ST_WR_A, ST_WR_B, ST_WR_CTL: begin
        if (xfer_done) begin
          if (resp_is_err(xfer_resp)) begin
            // a failed write aborts the rest of the sequence
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            state_d      = ST_RSP;
          end else begin
            xfer_start = 1'b1;
            case (state_q)
              ST_WR_A: begin
                xfer_addr  = C_CALC_BASE + AW'(CALC_REG_B);
                xfer_wdata = b_q;
                state_d    = ST_WR_B;
              end
              ST_WR_B: begin
                xfer_addr  = C_CALC_BASE + AW'(CALC_REG_CTL);
                xfer_wdata = {{(DW-2){1'b0}}, op_q};
                state_d    = ST_WR_CTL;
              end
              default: begin
                xfer_write = 1'b0;
                xfer_addr  = C_CALC_BASE + AW'(CALC_REG_RES);
                xfer_wdata = '0;
                state_d    = ST_RD_RES;
              end
            endcase
          end
        end
      end
      ST_RD_RES: begin
        if (xfer_done) begin
          rsp_result_d = xfer_rdata;
          rsp_err_d    = resp_is_err(xfer_resp);
          state_d      = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_hs) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      done_count_q <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        op_q <= cmd_op;
        b_q  <= cmd_b;
      end
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      done_count_q <= done_count_d;
      cmd_ready_q  <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      rsp_valid_q  <= (state_d == ST_RSP);
    end
  end

  calc_axil_xfer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_xfer (
    .clk_sys (m00_axi_aclk),
    .rst_b   (m00_axi_aresetn),
    .start_i (xfer_start),
    .write_i (xfer_write),
    .addr_i  (xfer_addr),
    .wdata_i (xfer_wdata),
    .done_o  (xfer_done),
    .rdata_o (xfer_rdata),
    .resp_o  (xfer_resp),
    .m_axi   (m00_axi)
  );

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_calc_axil_sequencer.sv
// Bench for calc_axil_sequencer: AXI4-Lite slave model with programmable waits/errors and a
// response scoreboard holding expected result, error flag, latency and bus traffic per command.
module tb_calc_axil_sequencer;
  import calc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_axil_sequencer_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;
  logic [15:0] done_count;

  calc_axil_sequencer #(
    .C_M00_AXI_ADDR_WIDTH (4),
    .C_M00_AXI_DATA_WIDTH (32),
    .C_CALC_BASE          (4'h0)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .done_count      (done_count),
    .m00_axi         (axi)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0;
  logic        wr_err_en = 1'b0;
  logic [3:0]  wr_err_addr = 4'h0;
  logic        rd_err_en = 1'b0;
  logic [31:0] res_reg = '0;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [3:0]  aw_addr_l;
  logic [31:0] w_data_l;
  logic        aw_hs, w_hs;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [35:0] act_wr[$];
  logic [3:0]  act_rd[$];

  always_comb begin
    axi.awready = axi.awvalid && !aw_got && (axi.awaddr != 4'h0 || aw_cnt >= aw_dly);
    axi.wready  = axi.wvalid && !w_got && (axi.awaddr != 4'h0 || w_cnt >= w_dly);
    axi.arready = axi.arvalid && !axi.rvalid;
    aw_hs   = axi.awvalid && axi.awready;
    w_hs    = axi.wvalid && axi.wready;
    wr_addr = aw_hs ? axi.awaddr : aw_addr_l;
    wr_data = w_hs ? axi.wdata : w_data_l;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0;
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
    end else begin
      if (axi.awvalid && !aw_hs && !aw_got) aw_cnt <= aw_cnt + 1;
      if (axi.wvalid && !w_hs && !w_got) w_cnt <= w_cnt + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= axi.awaddr; aw_cnt <= 0; end
      if (w_hs) begin w_got <= 1'b1; w_data_l <= axi.wdata; w_cnt <= 0; end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        act_wr.push_back({wr_addr, wr_data});
        axi.bvalid <= 1'b1;
        axi.bresp  <= (wr_err_en && wr_addr == wr_err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        act_rd.push_back(axi.araddr);
        axi.rvalid <= 1'b1;
        axi.rdata  <= (axi.araddr == 4'hC) ? res_reg : 32'hDEAD_BEEF;
        axi.rresp  <= rd_err_en ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          n_rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] exp_wr[$];
  logic [15:0] exp_count = '0;

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic err, input int n_wr,
                          input int n_rd, input int lat);
    logic [35:0] w[3];
    exp_t e;
    w[0] = {4'h0, a};
    w[1] = {4'h4, b};
    w[2] = {4'h8, 30'b0, op};
    for (int i = 0; i < n_wr; i++) exp_wr.push_back(w[i]);
    e.res = res; e.err = err; e.lat = lat; e.n_rd = n_rd;
    exp_q.push_back(e);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit slow);
    int n;
    exp_t e;
    e.res = '0; e.err = 1'b0; e.lat = -1; e.n_rd = -1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      if (n == 1) begin
        chk("awvalid_c1", {axi.awvalid, axi.wvalid, axi.awaddr}, {2'b11, 4'h0});
        chk("busy_c1", {busy, cmd_ready}, 2'b10);
        chk("prot_strb", {axi.awprot, axi.arprot, axi.wstrb}, {6'b0, 4'hF});
      end
      if (slow && n == 3) chk("slow_c3", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
      if (slow && n == 4) chk("slow_c4_bready", axi.bready, 0);
      if (slow && n == 5) chk("slow_c5_bready", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
    end while (!rsp_valid && n < 200);

    chk("sb_entries", exp_q.size(), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("latency", n, e.lat);
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_err", rsp_err, e.err);
    chk("n_writes", act_wr.size(), exp_wr.size());
    while (act_wr.size() > 0 && exp_wr.size() > 0) chk("write", act_wr.pop_front(), exp_wr.pop_front());
    act_wr.delete(); exp_wr.delete();
    chk("n_reads", act_rd.size(), e.n_rd);
    if (act_rd.size() > 0) chk("read_addr", act_rd[0], 4'hC);
    act_rd.delete();

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", {rsp_err, rsp_result}, {e.err, e.res});
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_count", done_count, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("done_count", done_count, exp_count);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_result}, 34'b0);
    chk("rst_status", {busy, cmd_ready, done_count}, 18'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", cmd_ready, 1);

    // zero-wait slave, basic add
    res_reg = 32'h0000_0008;
    push_exp(2'd0, 32'h5, 32'h3, 32'h8, 1'b0, 3, 1, 9);
    run_cmd(2'd0, 32'h5, 32'h3, 0, 1'b0);

    // AW waits 3 cycles, W waits 1 cycle on the first write
    aw_dly = 3; w_dly = 1;
    res_reg = 32'h0000_ABCD;
    push_exp(2'd2, 32'h1234, 32'h10, 32'hABCD, 1'b0, 3, 1, 12);
    run_cmd(2'd2, 32'h1234, 32'h10, 0, 1'b1);
    aw_dly = 0; w_dly = 0;

    // SLVERR on the operand B write
    wr_err_en = 1'b1; wr_err_addr = 4'h4;
    push_exp(2'd1, 32'h77, 32'h99, 32'h0, 1'b1, 2, 0, 5);
    run_cmd(2'd1, 32'h77, 32'h99, 0, 1'b0);
    wr_err_en = 1'b0;

    // response back-pressure
    res_reg = 32'h0000_0100;
    push_exp(2'd3, 32'hFFFF_FFFF, 32'h1, 32'h100, 1'b0, 3, 1, 9);
    run_cmd(2'd3, 32'hFFFF_FFFF, 32'h1, 5, 1'b0);

    // SLVERR on the result read
    rd_err_en = 1'b1;
    res_reg = 32'h0000_0055;
    push_exp(2'd1, 32'hA, 32'hB, 32'h55, 1'b1, 3, 1, 9);
    run_cmd(2'd1, 32'hA, 32'hB, 0, 1'b0);
    rd_err_en = 1'b0;

    // preload the counter one short of wrap
    force dut.done_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.done_count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    chk("count_preset", done_count, exp_count);
    res_reg = 32'h0000_0042;
    push_exp(2'd0, 32'h40, 32'h2, 32'h42, 1'b0, 3, 1, 9);
    run_cmd(2'd0, 32'h40, 32'h2, 0, 1'b0);
    chk("count_wrapped", done_count, 16'h0000);

    // reset pulse during WR_B
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 32'h111; cmd_b = 32'h222;
    n = 0;
    do begin @(negedge clk); n++; cmd_valid = 1'b0; end while (n < 3);
    chk("rst_mid_pre", {axi.awvalid, axi.awaddr}, {1'b1, 4'h4});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
    chk("rst_mid_status", {busy, rsp_valid, cmd_ready}, 3'b0);
    @(negedge clk);
    rst_n = 1'b1;
    act_wr.delete(); act_rd.delete();
    exp_count = 16'h0;
    @(negedge clk);
    chk("rst_mid_idle", {cmd_ready, busy, done_count}, {2'b10, exp_count});
    res_reg = 32'h0000_0333;
    push_exp(2'd2, 32'h111, 32'h222, 32'h333, 1'b0, 3, 1, 9);
    run_cmd(2'd2, 32'h111, 32'h222, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
